rename_unit_nwide: RTL and testbench
====================================

RENAME_UNIT_NWIDE -- requirements
Module: rename_unit_nwide

Interface
REQ-001 SHALL have parameter WIDTH, default 8: rename slots per cycle, legal range 1..8.
REQ-002 SHALL have parameter ARCH_REGS, default 32: architectural registers; register 0 is hard-wired to zero.
REQ-003 SHALL have parameter PHYS_REGS, default 128: physical registers, a power of two and greater than ARCH_REGS; PW = log2(PHYS_REGS), AW = log2(ARCH_REGS).
REQ-004 SHALL have parameter CKPT_DEPTH, default 16: checkpoint stack entries.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid_i, input, WIDTH bits: per-slot instruction valid.
REQ-008 SHALL have ports rs1_arch_i, rs2_arch_i and rd_arch_i, input, WIDTH x AW each: architectural source and destination registers.
REQ-009 SHALL have port ckpt_i, input, 1 bit: take a checkpoint after this group.
REQ-010 SHALL have port in_ready_o, output, 1 bit: the group is accepted this cycle.
REQ-011 SHALL have port out_valid_o, output, WIDTH bits: registered per-slot rename valid.
REQ-012 SHALL have ports rs1_phys_o, rs2_phys_o, rd_phys_o and old_rd_phys_o, output, WIDTH x PW each: registered rename results.
REQ-013 SHALL have ports free_valid_i (input, WIDTH bits) and free_phys_i (input, WIDTH x PW): commit-side register returns.
REQ-014 SHALL have port rollback_i, input, 1 bit: restore the most recent checkpoint.
REQ-015 SHALL have ports free_count_o (output, PW+1 bits), ckpt_full_o (output, 1 bit) and ckpt_count_o (output, log2(CKPT_DEPTH)+1 bits).

Function
REQ-016 Slot k SHALL need a new register, "alloc_k", only when in_valid_i[k]=1 and rd_arch_i[k]!=0.
REQ-017 in_ready_o SHALL be 1 only when all of these hold: free_count_o >= popcount(alloc); not (ckpt_i and ckpt_full_o); rollback_i=0.
REQ-018 Acceptance SHALL be all-or-nothing for a group; there are no partial groups.
REQ-019 On acceptance, allocating slots SHALL take free-list entries head, head+1, ... in ascending slot order; head advances by popcount(alloc).
REQ-020 Intra-group bypass: a source in slot k SHALL map to the rd_phys of the highest slot j<k that allocated the same architectural register, otherwise to the current map.
REQ-021 old_rd_phys_o[k] SHALL follow the same bypass rule applied to rd_arch_i[k].
REQ-022 On a WAW hit within a group, the map SHALL end holding the highest slot's register.
REQ-023 A non-allocating valid slot SHALL output rd_phys = old_rd_phys = map[rd], with out_valid=1.
REQ-024 Architectural register 0 SHALL always map to physical 0 and is never allocated.
REQ-025 Outputs SHALL have 1-cycle latency; out_valid_o SHALL be in_valid_i of an accepted group, and 0 otherwise.
REQ-026 Free list SHALL be a PHYS_REGS-entry circular buffer with (PW+1)-bit head/tail pointers; free_count_o = tail-head.
REQ-027 Frees SHALL be written at tail in ascending slot order every cycle, regardless of stall or rollback.
REQ-028 On acceptance with ckpt_i=1, the map after the group plus the new head SHALL be pushed; ckpt_count increments.
REQ-029 On rollback_i with ckpt_count>0, the map and head SHALL be restored from the top entry and the entry popped; free_count is recomputed from the current tail.
REQ-030 A rollback with ckpt_count=0 SHALL be ignored; rollback takes priority over rename.
REQ-031 ckpt_full_o SHALL be 1 when ckpt_count == CKPT_DEPTH.

Reset
REQ-032 rst SHALL set map[i]=i, free-list entry j = ARCH_REGS+j, head=0, tail=PHYS_REGS-ARCH_REGS, ckpt_count=0, all outputs 0, and out_valid_o=0.
REQ-033 rst mid-operation SHALL abandon all in-flight state within the same cycle.

Configuration
REQ-034 With macro RENAME_UNIT_CKPT_EN defined, the checkpoint stack and rollback SHALL be present per REQ-028 to REQ-031.
REQ-035 Without RENAME_UNIT_CKPT_EN: ckpt_i and rollback_i SHALL be ignored, ckpt_full_o=0, ckpt_count_o=0, and no stack storage is built.

Verification
REQ-036 After reset, slots 0-7 valid with rd=1..8 -> rd_phys 32..39, old_rd 1..8, free_count 88.
REQ-037 Slot0 rd=5 and slot1 rs1=5, rd=5 -> slot1 rs1_phys=32, old_rd=32, rd_phys=33, final map[5]=33.
REQ-038 free_count=3 and a group needs 4 -> in_ready_o=0 and out_valid_o=0; with 1 free in that cycle, accepted next cycle.
REQ-039 ckpt_i with group rd=3, then group rd=3 again, then rollback_i -> map[3]=32, head back to 1, ckpt_count 0.
REQ-040 Fill the stack with 16 checkpoints -> ckpt_full_o=1 and a group with ckpt_i stalls; rollback with empty stack is a no-op.

Source files
------------

// File: rtl/rename_unit_nwide.sv
// rename_unit_nwide: N-wide register rename with circular free list.
// Optional checkpoint stack and rollback under `define RENAME_UNIT_CKPT_EN.
module rename_unit_nwide #(
   parameter int WIDTH      = 8,
   parameter int ARCH_REGS  = 32,
   parameter int PHYS_REGS  = 128,
   parameter int CKPT_DEPTH = 16,
   localparam int PW = $clog2(PHYS_REGS),
   localparam int AW = $clog2(ARCH_REGS),
   localparam int CW = $clog2(CKPT_DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_valid_i,
   input  logic [WIDTH-1:0][AW-1:0] rs1_arch_i,
   input  logic [WIDTH-1:0][AW-1:0] rs2_arch_i,
   input  logic [WIDTH-1:0][AW-1:0] rd_arch_i,
   input  logic                     ckpt_i,
   output logic                     in_ready_o,
   output logic [WIDTH-1:0]         out_valid_o,
   output logic [WIDTH-1:0][PW-1:0] rs1_phys_o,
   output logic [WIDTH-1:0][PW-1:0] rs2_phys_o,
   output logic [WIDTH-1:0][PW-1:0] rd_phys_o,
   output logic [WIDTH-1:0][PW-1:0] old_rd_phys_o,
   input  logic [WIDTH-1:0]         free_valid_i,
   input  logic [WIDTH-1:0][PW-1:0] free_phys_i,
   input  logic                     rollback_i,
   output logic [PW:0]              free_count_o,
   output logic                     ckpt_full_o,
   output logic [CW-1:0]            ckpt_count_o
);

   logic [PW-1:0] map_q [ARCH_REGS];
   logic [PW-1:0] fl_q  [PHYS_REGS];
   logic [PW-1:0] nmap  [ARCH_REGS];
   logic [PW-1:0] rb_map [ARCH_REGS];
   logic [PW:0]   head_q, tail_q, tail_nx, rb_head, n_alloc;
   logic [WIDTH-1:0] alloc;
   logic [WIDTH-1:0][PW-1:0] rs1_p, rs2_p, rd_p, old_p, fw_idx;
   logic rb_req, rb_take;

   assign free_count_o = tail_q - head_q;
   assign in_ready_o = (free_count_o >= n_alloc)
                     && !(ckpt_i && ckpt_full_o)
                     && !rb_req;

   // Rename slots in order; nmap carries earlier slots' writes forward as bypass.
   always_comb begin
      logic [PW:0] rp;
      rp      = head_q;
      nmap    = map_q;
      n_alloc = '0;
      alloc   = '0;
      rs1_p   = '0;
      rs2_p   = '0;
      rd_p    = '0;
      old_p   = '0;
      for (int k = 0; k < WIDTH; k++) begin
         alloc[k] = in_valid_i[k] && (rd_arch_i[k] != '0);
         rs1_p[k] = nmap[rs1_arch_i[k]];
         rs2_p[k] = nmap[rs2_arch_i[k]];
         old_p[k] = nmap[rd_arch_i[k]];
         rd_p[k]  = old_p[k];
         if (alloc[k]) begin
            rd_p[k] = fl_q[rp[PW-1:0]];
            nmap[rd_arch_i[k]] = rd_p[k];
            rp      = rp + (PW+1)'(1);
            n_alloc = n_alloc + (PW+1)'(1);
         end
      end
   end

   // Pack returned registers at the tail in ascending slot order.
   always_comb begin
      logic [PW:0] wp;
      wp     = tail_q;
      fw_idx = '0;
      for (int k = 0; k < WIDTH; k++) begin
         fw_idx[k] = wp[PW-1:0];
         if (free_valid_i[k]) wp = wp + (PW+1)'(1);
      end
      tail_nx = wp;
   end

`ifdef RENAME_UNIT_CKPT_EN
   logic [PW-1:0] ck_map  [CKPT_DEPTH][ARCH_REGS];
   logic [PW:0]   ck_head [CKPT_DEPTH];
   logic [CW-1:0] ck_cnt_q, ck_top;
   logic          ck_push;

   assign ck_top       = ck_cnt_q - CW'(1);
   assign ckpt_full_o  = (ck_cnt_q == CW'(CKPT_DEPTH));
   assign ckpt_count_o = ck_cnt_q;
   assign rb_req       = rollback_i;
   assign rb_take      = rollback_i && (ck_cnt_q != '0);
   assign ck_push      = in_ready_o && ckpt_i;
   assign rb_map       = ck_map[ck_top[CW-2:0]];
   assign rb_head      = ck_head[ck_top[CW-2:0]];

   // Push the post-group map and head on checkpoint; pop on rollback.
   always_ff @(posedge clk) begin
      if (rst) begin
         ck_cnt_q <= '0;
      end else if (rb_take) begin
         ck_cnt_q <= ck_top;
      end else if (ck_push) begin
         ck_map[ck_cnt_q[CW-2:0]]  <= nmap;
         ck_head[ck_cnt_q[CW-2:0]] <= head_q + n_alloc;
         ck_cnt_q <= ck_cnt_q + CW'(1);
      end
   end
`else
   logic unused_ckpt;

   assign unused_ckpt  = ckpt_i ^ rollback_i;
   assign ckpt_full_o  = 1'b0;
   assign ckpt_count_o = '0;
   assign rb_req       = 1'b0;
   assign rb_take      = 1'b0;
   assign rb_map       = map_q;
   assign rb_head      = head_q;
`endif

   // Map table, free list storage/pointers and registered rename results.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
         for (int j = 0; j < PHYS_REGS; j++) fl_q[j] <= PW'(ARCH_REGS + j);
         head_q        <= '0;
         tail_q        <= (PW+1)'(PHYS_REGS - ARCH_REGS);
         out_valid_o   <= '0;
         rs1_phys_o    <= '0;
         rs2_phys_o    <= '0;
         rd_phys_o     <= '0;
         old_rd_phys_o <= '0;
      end else begin
         for (int k = 0; k < WIDTH; k++)
            if (free_valid_i[k]) fl_q[fw_idx[k]] <= free_phys_i[k];
         tail_q      <= tail_nx;
         out_valid_o <= '0;
         if (rb_take) begin
            map_q  <= rb_map;
            head_q <= rb_head;
         end else if (in_ready_o) begin
            map_q         <= nmap;
            head_q        <= head_q + n_alloc;
            out_valid_o   <= in_valid_i;
            rs1_phys_o    <= rs1_p;
            rs2_phys_o    <= rs2_p;
            rd_phys_o     <= rd_p;
            old_rd_phys_o <= old_p;
         end
      end
   end

endmodule

// File: tb/tb_rename_unit_nwide.sv
// tb_rename_unit_nwide: random and directed stimulus, scoreboard checking
// against a queue-based rename model.
module tb_rename_unit_nwide;

   localparam int W  = 8;
   localparam int NA = 32;
   localparam int NP = 128;
   localparam int CD = 16;
`ifdef RENAME_UNIT_CKPT_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0]      in_valid_i = '0;
   logic [7:0][4:0] rs1_arch_i = '0;
   logic [7:0][4:0] rs2_arch_i = '0;
   logic [7:0][4:0] rd_arch_i = '0;
   logic            ckpt_i = 1'b0;
   logic            in_ready_o;
   logic [7:0]      out_valid_o;
   logic [7:0][6:0] rs1_phys_o, rs2_phys_o, rd_phys_o, old_rd_phys_o;
   logic [7:0]      free_valid_i = '0;
   logic [7:0][6:0] free_phys_i = '0;
   logic            rollback_i = 1'b0;
   logic [7:0]      free_count_o;
   logic            ckpt_full_o;
   logic [4:0]      ckpt_count_o;

   rename_unit_nwide dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid_i),
      .rs1_arch_i(rs1_arch_i), .rs2_arch_i(rs2_arch_i), .rd_arch_i(rd_arch_i),
      .ckpt_i(ckpt_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
      .rs1_phys_o(rs1_phys_o), .rs2_phys_o(rs2_phys_o),
      .rd_phys_o(rd_phys_o), .old_rd_phys_o(old_rd_phys_o),
      .free_valid_i(free_valid_i), .free_phys_i(free_phys_i),
      .rollback_i(rollback_i), .free_count_o(free_count_o),
      .ckpt_full_o(ckpt_full_o), .ckpt_count_o(ckpt_count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]      v;
      logic [7:0][6:0] r1, r2, rd, od;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;

   logic [NA-1:0][6:0] mmap;
   int fl[$];
   int alog[$];
   logic [NA-1:0][6:0] ck_map[$];
   int ck_log[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < NA; i++) mmap[i] = 7'(i);
      fl.delete();
      for (int j = NA; j < NP; j++) fl.push_back(j);
      alog.delete();
      ck_map.delete();
      ck_log.delete();
   endtask

   // Space left in the circular buffer that frees may use without
   // overwriting entries a rollback could still bring back.
   function automatic int room();
      int live;
      live = fl.size();
      if (ck_log.size() > 0) live += alog.size() - ck_log[0];
      return NP - live;
   endfunction

   function automatic logic [6:0] see(input int k, input logic [4:0] r,
                                      input logic [7:0] al,
                                      input logic [7:0][4:0] ad,
                                      input int nr [8]);
      for (int j = k - 1; j >= 0; j--)
         if (al[j] && ad[j] == r) return 7'(nr[j]);
      return mmap[r];
   endfunction

   task automatic drive(input logic [7:0] v, input logic [7:0][4:0] a1,
                        input logic [7:0][4:0] a2, input logic [7:0][4:0] ad,
                        input logic ck, input logic rb,
                        input logic [7:0] fv, input logic [7:0][6:0] fp);
      logic [7:0] al;
      int need, lsz;
      bit rdy;
      int nr [8];
      exp_t e;
      in_valid_i = v; rs1_arch_i = a1; rs2_arch_i = a2; rd_arch_i = ad;
      ckpt_i = ck; rollback_i = rb; free_valid_i = fv; free_phys_i = fp;
      #1;
      need = 0;
      for (int k = 0; k < W; k++) begin
         al[k] = v[k] && (ad[k] != 0);
         nr[k] = 0;
         if (al[k]) need++;
      end
      rdy = (fl.size() >= need);
      if (CK_EN && ck && ck_map.size() == CD) rdy = 0;
      if (CK_EN && rb) rdy = 0;
      chk("in_ready", in_ready_o, rdy);
      chk("free_count", free_count_o, fl.size());
      chk("ckpt_count", ckpt_count_o, ck_map.size());
      chk("ckpt_full", ckpt_full_o, CK_EN && ck_map.size() == CD);
      if (CK_EN && rb) begin
         if (ck_map.size() > 0) begin
            mmap = ck_map.pop_back();
            lsz = ck_log.pop_back();
            while (alog.size() > lsz) fl.push_front(alog.pop_back());
         end
      end else if (rdy) begin
         e = '0;
         e.v = v;
         for (int k = 0; k < W; k++)
            if (al[k]) begin
               nr[k] = fl.pop_front();
               alog.push_back(nr[k]);
            end
         for (int k = 0; k < W; k++) begin
            e.r1[k] = see(k, a1[k], al, ad, nr);
            e.r2[k] = see(k, a2[k], al, ad, nr);
            e.od[k] = see(k, ad[k], al, ad, nr);
            e.rd[k] = al[k] ? 7'(nr[k]) : e.od[k];
         end
         for (int k = 0; k < W; k++)
            if (al[k]) mmap[ad[k]] = 7'(nr[k]);
         if (CK_EN && ck) begin
            ck_map.push_back(mmap);
            ck_log.push_back(alog.size());
         end
         if (v != 0) sb.push_back(e);
      end
      for (int k = 0; k < W; k++)
         if (fv[k]) fl.push_back(int'(fp[k]));
   endtask

   task automatic go(input logic [7:0] v, input logic [7:0][4:0] a1,
                     input logic [7:0][4:0] ad, input logic ck, input logic rb);
      @(negedge clk);
      drive(v, a1, '0, ad, ck, rb, '0, '0);
   endtask

   task automatic idle();
      go('0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid_i = 8'hFF;
      for (int k = 0; k < W; k++) rd_arch_i[k] = 5'($urandom_range(1, 31));
      free_valid_i = 8'hFF;
      free_phys_i = '1;
      ckpt_i = 1'b1;
      rollback_i = 1'b0;
      @(negedge clk);
      reset_model();
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_rd_phys", rd_phys_o, 0);
      chk("rst_free_count", free_count_o, 96);
      chk("rst_ckpt_count", ckpt_count_o, 0);
      rst = 1'b0;
      in_valid_i = '0; rd_arch_i = '0; free_valid_i = '0;
      free_phys_i = '0; ckpt_i = 1'b0;
   endtask

   task automatic rand_step(input int cyc);
      logic [7:0] v, fv;
      logic [7:0][4:0] a1, a2, ad;
      logic [7:0][6:0] fp;
      int rm, fprob;
      rm = room();
      fprob = ((cyc / 150) % 2 == 1) ? 9 : 2;
      fv = '0;
      fp = '0;
      for (int k = 0; k < W; k++) begin
         v[k]  = ($urandom_range(0, 9) < 7);
         a1[k] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         a2[k] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         ad[k] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         if (rm > 0 && $urandom_range(0, 9) < fprob) begin
            fv[k] = 1'b1;
            fp[k] = 7'($urandom_range(1, 127));
            rm--;
         end
      end
      @(negedge clk);
      drive(v, a1, a2, ad, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0), fv, fp);
   endtask

   // Monitor: pop one expected group whenever the DUT shows a valid output.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid_o != 0) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got out_valid=%0h want none", out_valid_o);
            end else begin
               e = sb.pop_front();
               chk("out_valid", out_valid_o, e.v);
               for (int k = 0; k < W; k++)
                  if (e.v[k]) begin
                     chk($sformatf("rs1_phys[%0d]", k), rs1_phys_o[k], e.r1[k]);
                     chk($sformatf("rs2_phys[%0d]", k), rs2_phys_o[k], e.r2[k]);
                     chk($sformatf("rd_phys[%0d]", k), rd_phys_o[k], e.rd[k]);
                     chk($sformatf("old_rd_phys[%0d]", k), old_rd_phys_o[k], e.od[k]);
                  end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0][4:0] a1, ad;
      logic [7:0][6:0] fp;
      reset_model();
      do_reset();

      // Full-width group after reset.
      for (int k = 0; k < W; k++) ad[k] = 5'(k + 1);
      go(8'hFF, '0, ad, 1'b0, 1'b0);
      idle();
      chk("d36_rd0", rd_phys_o[0], 32);
      chk("d36_rd7", rd_phys_o[7], 39);
      chk("d36_old7", old_rd_phys_o[7], 8);
      chk("d36_free", free_count_o, 88);

      // In-group bypass and WAW.
      do_reset();
      a1 = '0; ad = '0;
      ad[0] = 5'd5; a1[1] = 5'd5; ad[1] = 5'd5;
      go(8'h03, a1, ad, 1'b0, 1'b0);
      idle();
      chk("d37_rs1", rs1_phys_o[1], 32);
      chk("d37_old", old_rd_phys_o[1], 32);
      chk("d37_rd", rd_phys_o[1], 33);
      a1 = '0; ad = '0; a1[0] = 5'd5;
      go(8'h01, a1, ad, 1'b0, 1'b0);
      idle();
      chk("d37_map5", rs1_phys_o[0], 33);

      // Stall on a short free list, then accept once a free arrives.
      do_reset();
      for (int k = 0; k < W; k++) ad[k] = 5'(k + 1);
      repeat (11) go(8'hFF, '0, ad, 1'b0, 1'b0);
      go(8'h1F, '0, ad, 1'b0, 1'b0);
      @(negedge clk);
      fp = '0;
      fp[0] = 7'd100;
      drive(8'h0F, '0, '0, ad, 1'b0, 1'b0, 8'h01, fp);
      chk("d38_stall", in_ready_o, 0);
      go(8'h0F, '0, ad, 1'b0, 1'b0);
      chk("d38_stall_out", out_valid_o, 0);
      chk("d38_ready", in_ready_o, 1);
      idle();
      chk("d38_out", out_valid_o, 8'h0F);
      chk("d38_rd3", rd_phys_o[3], 100);

      // Checkpoint, overwrite, roll back.
      do_reset();
      a1 = '0; ad = '0; ad[0] = 5'd3;
      go(8'h01, '0, ad, 1'b1, 1'b0);
      go(8'h01, '0, ad, 1'b0, 1'b0);
      go('0, '0, '0, 1'b0, 1'b1);
      idle();
`ifdef RENAME_UNIT_CKPT_EN
      chk("d39_free", free_count_o, 95);
`else
      chk("d39_free", free_count_o, 94);
`endif
      chk("d39_count", ckpt_count_o, 0);
      a1[0] = 5'd3; ad = '0;
      go(8'h01, a1, ad, 1'b0, 1'b0);
      idle();
`ifdef RENAME_UNIT_CKPT_EN
      chk("d39_map3", rs1_phys_o[0], 32);
`else
      chk("d39_map3", rs1_phys_o[0], 33);
`endif

      // Fill the stack, stall on full, drain, rollback on empty.
      do_reset();
      repeat (CD) go('0, '0, '0, 1'b1, 1'b0);
      ad = '0; ad[0] = 5'd1;
      go(8'h01, '0, ad, 1'b1, 1'b0);
`ifdef RENAME_UNIT_CKPT_EN
      chk("d40_full", ckpt_full_o, 1);
      chk("d40_count", ckpt_count_o, 16);
      chk("d40_stall", in_ready_o, 0);
`else
      chk("d40_full", ckpt_full_o, 0);
      chk("d40_count", ckpt_count_o, 0);
      chk("d40_stall", in_ready_o, 1);
`endif
      repeat (CD) go('0, '0, '0, 1'b0, 1'b1);
      go('0, '0, '0, 1'b0, 1'b1);
      idle();
      chk("d40_empty", ckpt_count_o, 0);
`ifdef RENAME_UNIT_CKPT_EN
      chk("d40_free", free_count_o, 96);
`else
      chk("d40_free", free_count_o, 95);
`endif

      // Random traffic with a reset in the middle.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         rand_step(c);
      end
      idle();
      idle();
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
